// File: rtl/wb_arbiter.sv
// Two-master, single-slave Wishbone classic arbiter: round-robin, grant held for a whole cyc.
// Optional stall watchdog compiled in with WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    input  logic [31:0] s_dat_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT must be within 2..65535");
    end

    state_t state, state_nxt;
    logic   last, last_nxt;

    logic        req_cyc, req_stb, req_we;
    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        term;
    logic        timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // last names the master served most recently; a tie goes to the other one
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_nxt = last ? GRANT0 : GRANT1;
                else if (m0_cyc_i)
                    state_nxt = GRANT0;
                else if (m1_cyc_i)
                    state_nxt = GRANT1;
            end
            GRANT0: begin
                if (!m0_cyc_i) begin
                    last_nxt  = 1'b0;
                    state_nxt = m1_cyc_i ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (!m1_cyc_i) begin
                    last_nxt  = 1'b1;
                    state_nxt = m0_cyc_i ? GRANT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_cyc = 1'b0;
        req_stb = 1'b0;
        req_we  = 1'b0;
        req_adr = '0;
        req_sel = '0;
        req_dat = '0;
        case (state)
            GRANT0: begin
                req_cyc = m0_cyc_i;
                req_stb = m0_stb_i;
                req_we  = m0_we_i;
                req_adr = m0_adr_i;
                req_sel = m0_sel_i;
                req_dat = m0_dat_i;
            end
            GRANT1: begin
                req_cyc = m1_cyc_i;
                req_stb = m1_stb_i;
                req_we  = m1_we_i;
                req_adr = m1_adr_i;
                req_sel = m1_sel_i;
                req_dat = m1_dat_i;
            end
            default: ;
        endcase
    end

    assign term = (state != IDLE) && (s_ack_i || s_err_i || s_rty_i);

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    logic [15:0] wdt_cnt;

    // A real slave termination in the timeout cycle wins over the injected error
    assign timeout = req_cyc && req_stb && !term && (wdt_cnt == TIMEOUT_W);

    always_ff @(posedge clk_i) begin
        if (rst_i || term || timeout || !(req_cyc && req_stb))
            wdt_cnt <= '0;
        else
            wdt_cnt <= wdt_cnt + 16'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign s_cyc_o = req_cyc && !timeout;
    assign s_stb_o = req_stb && !timeout;
    assign s_we_o  = req_we;
    assign s_adr_o = req_adr;
    assign s_sel_o = req_sel;
    assign s_dat_o = req_dat;

    assign m0_ack_o = (state == GRANT0) && s_ack_i;
    assign m0_err_o = (state == GRANT0) && (s_err_i || timeout);
    assign m0_rty_o = (state == GRANT0) && s_rty_i;
    assign m1_ack_o = (state == GRANT1) && s_ack_i;
    assign m1_err_o = (state == GRANT1) && (s_err_i || timeout);
    assign m1_rty_o = (state == GRANT1) && s_rty_i;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_wb_arbiter;

    localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hB000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o, m0_rty_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o, m1_rty_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [31:0] s_dat_i;

    int checks = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i)
    );

    // Reference model: who owns the bus, who was served last, how long the current strobe has stalled
    int m_owner = -1;
    int m_last  = 1;
    int m_stall = 0;

    function automatic logic in_cyc(int n);
        return (n == 0) ? m0_cyc_i : m1_cyc_i;
    endfunction

    function automatic logic in_stb(int n);
        return (n == 0) ? m0_stb_i : m1_stb_i;
    endfunction

    function automatic bit model_req();
        return (m_owner >= 0) && in_cyc(m_owner) && in_stb(m_owner);
    endfunction

    function automatic bit model_term();
        return (m_owner >= 0) && (s_ack_i || s_err_i || s_rty_i);
    endfunction

    function automatic bit model_to();
        return TO_EN && model_req() && !model_term() && (m_stall == TO);
    endfunction

    always @(posedge clk_i) begin : ref_model
        bit req, trm, to;
        req = model_req();
        trm = model_term();
        to  = model_to();
        if (rst_i) begin
            m_owner = -1;
            m_last  = 1;
            m_stall = 0;
        end else begin
            m_stall = (req && !trm && !to) ? m_stall + 1 : 0;
            if (m_owner < 0) begin
                if (m0_cyc_i && m1_cyc_i) m_owner = 1 - m_last;
                else if (m0_cyc_i)        m_owner = 0;
                else if (m1_cyc_i)        m_owner = 1;
            end else if (!in_cyc(m_owner)) begin
                m_last  = m_owner;
                m_owner = in_cyc(1 - m_owner) ? 1 - m_owner : -1;
            end
        end
    end

    function automatic logic [140:0] model_vec();
        logic        cyc, stb, we, to;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic [2:0]  t0, t1;
        to = model_to();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
        t0 = '0; t1 = '0;
        if (m_owner == 0) begin
            cyc = m0_cyc_i & ~to; stb = m0_stb_i & ~to; we = m0_we_i;
            adr = m0_adr_i; sel = m0_sel_i; dat = m0_dat_i;
            t0 = {s_ack_i, s_err_i | to, s_rty_i};
        end else if (m_owner == 1) begin
            cyc = m1_cyc_i & ~to; stb = m1_stb_i & ~to; we = m1_we_i;
            adr = m1_adr_i; sel = m1_sel_i; dat = m1_dat_i;
            t1 = {s_ack_i, s_err_i | to, s_rty_i};
        end
        return {cyc, stb, we, adr, sel, dat, t0, s_dat_i, t1, s_dat_i};
    endfunction

    function automatic logic [140:0] dut_vec();
        return {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
                m0_ack_o, m0_err_o, m0_rty_o, m0_dat_o,
                m1_ack_o, m1_err_o, m1_rty_o, m1_dat_o};
    endfunction

    function automatic logic [76:0] ctl_vec();
        return {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
                m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = A0; m0_sel_i = 4'hF; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = A1; m1_sel_i = 4'hF; m1_dat_i = '0;
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1;
        m0_cyc_i = 1; m0_stb_i = 1;
        s_ack_i = 1; s_err_i = 1; s_rty_i = 1;
        tick();
        tick();
        @(negedge clk_i);
        checks++;
        if (ctl_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", ctl_vec());
        else passed++;
        rst_i = 0;
        clear_inputs();
        tick();
    endtask

    task automatic test_single();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h2000_0000;
        @(negedge clk_i);
        checks++;
        if (s_stb_o !== 1'b0) $display("FAIL single_latency: s_stb_o=%b want 0", s_stb_o);
        else passed++;
        tick();
        @(negedge clk_i);
        checks++;
        if ({s_stb_o, s_cyc_o, s_we_o, s_adr_o} !== {3'b110, 32'h2000_0000})
            $display("FAIL single_request: stb/cyc/we=%b%b%b adr=%h want 110 20000000",
                     s_stb_o, s_cyc_o, s_we_o, s_adr_o);
        else passed++;
        tick();
        @(negedge clk_i);
        checks++;
        if (m0_ack_o !== 1'b0) $display("FAIL single_wait: m0_ack_o=%b want 0", m0_ack_o);
        else passed++;
        tick();
        s_ack_i = 1; s_dat_i = 32'h0000_0001;
        @(negedge clk_i);
        checks++;
        if ({m0_ack_o, m0_dat_o, m1_ack_o} !== {1'b1, 32'h0000_0001, 1'b0})
            $display("FAIL single_ack: m0_ack=%b m0_dat=%h m1_ack=%b want 1 00000001 0",
                     m0_ack_o, m0_dat_o, m1_ack_o);
        else passed++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h1000_0000;
        tick();
        s_ack_i = 1;
        @(negedge clk_i);
        checks++;
        if ({s_adr_o, m0_ack_o, m1_ack_o} !== {A0, 2'b10})
            $display("FAIL tie_first: adr=%h ack0=%b ack1=%b want %h 1 0", s_adr_o, m0_ack_o, m1_ack_o, A0);
        else passed++;
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        s_ack_i = 1;
        @(negedge clk_i);
        checks++;
        if ({s_cyc_o, s_adr_o, m0_ack_o, m1_ack_o} !== {1'b1, 32'h1000_0000, 2'b01})
            $display("FAIL tie_handover: cyc=%b adr=%h ack0=%b ack1=%b want 1 10000000 0 1",
                     s_cyc_o, s_adr_o, m0_ack_o, m1_ack_o);
        else passed++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        m1_cyc_i = 1; m1_stb_i = 1;
        for (int g = 0; g < 8; g++) begin
            int  n;
            bit  found;
            int  owner;
            n = 0;
            found = 0;
            while (n < 10 && !found) begin
                @(negedge clk_i);
                if (s_cyc_o && s_stb_o) found = 1;
                else begin tick(); n++; end
            end
            owner = (s_adr_o == A1) ? 1 : 0;
            checks++;
            if (!found || owner != (g % 2))
                $display("FAIL rr_order[%0d]: granted m%0d found=%0d want m%0d", g, owner, found, g % 2);
            else passed++;
            s_ack_i = 1;
            tick();
            s_ack_i = 0;
            if (owner == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
            else            begin m1_cyc_i = 0; m1_stb_i = 0; end
            tick();
            if (owner == 0) begin m0_cyc_i = 1; m0_stb_i = 1; end
            else            begin m1_cyc_i = 1; m1_stb_i = 1; end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        m1_stb_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            checks++;
            if ({s_cyc_o, s_stb_o, s_adr_o} !== {2'b10, A1})
                $display("FAIL lock_hold[%0d]: cyc=%b stb=%b adr=%h want 1 0 %h", k, s_cyc_o, s_stb_o, s_adr_o, A1);
            else passed++;
            tick();
        end
        m1_cyc_i = 0;
        @(negedge clk_i);
        checks++;
        if (s_cyc_o !== 1'b0) $display("FAIL lock_release: cyc=%b want 0", s_cyc_o);
        else passed++;
        tick();
        @(negedge clk_i);
        checks++;
        if ({s_cyc_o, s_stb_o, s_adr_o} !== {2'b11, A0})
            $display("FAIL lock_next: cyc=%b stb=%b adr=%h want 1 1 %h", s_cyc_o, s_stb_o, s_adr_o, A0);
        else passed++;
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        n = 0;
        @(negedge clk_i);
        while (!s_stb_o && n < 5) begin
            tick();
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 5) $display("FAIL timeout_start: s_stb_o never rose, want rise");
        else passed++;
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 0; i <= 12; i++) begin
            bit exp_err;
            if (i > 0) begin tick(); @(negedge clk_i); end
            exp_err = (i == TO);
            checks++;
            if ({m0_err_o, s_cyc_o, m1_err_o} !== {exp_err, !exp_err, 1'b0})
                $display("FAIL timeout_cycle[%0d]: err0=%b cyc=%b err1=%b want %b %b 0",
                         i, m0_err_o, s_cyc_o, m1_err_o, exp_err, !exp_err);
            else passed++;
        end
`else
        begin
            int errs;
            errs = 0;
            for (int i = 0; i < 40; i++) begin
                if (m0_err_o || m1_err_o) errs++;
                tick();
                @(negedge clk_i);
            end
            checks++;
            if (errs != 0 || s_cyc_o !== 1'b1)
                $display("FAIL timeout_disabled: errs=%0d cyc=%b want 0 1", errs, s_cyc_o);
            else passed++;
        end
`endif
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        tick();
        rst_i = 1;
        s_ack_i = 1; s_err_i = 1; s_rty_i = 1;
        tick();
        rst_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk_i);
        checks++;
        if (ctl_vec() !== '0) $display("FAIL reset_mid_outputs: got %h want 0", ctl_vec());
        else passed++;
        tick();
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
        @(negedge clk_i);
        checks++;
        if ({s_cyc_o, s_adr_o} !== {1'b1, A0})
            $display("FAIL reset_mid_tie: cyc=%b adr=%h want 1 %h", s_cyc_o, s_adr_o, A0);
        else passed++;
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [140:0] exp_v;
        int           errs;
        do_reset();
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(5) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = m0_cyc_i && ($urandom_range(3) != 0);
            m1_stb_i = m1_cyc_i && ($urandom_range(3) != 0);
            m0_we_i  = 1'($urandom);
            m1_we_i  = 1'($urandom);
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
            s_ack_i  = ($urandom_range(11) == 0);
            s_err_i  = ($urandom_range(39) == 0);
            s_rty_i  = ($urandom_range(39) == 0);
            s_dat_i  = $urandom;
            rst_i    = ($urandom_range(299) == 0);
            @(negedge clk_i);
            exp_v = model_vec();
            checks++;
            if (dut_vec() !== exp_v) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: got %h want %h", c, dut_vec(), exp_v);
                errs++;
            end else passed++;
            tick();
        end
        rst_i = 0;
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_i = 1;
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
